// File: rtl/ysyx_22050612_seq_ctrl.sv
// Multi-cycle instruction sequencer: steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
// It owns the PC, the fetch and data request handshakes, the register-file write strobe and the halt/error state.
module ysyx_22050612_seq_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
    parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,

    output logic        ifu_req,
    output logic [63:0] ifu_addr,
    input  logic        ifu_ack,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst,

    input  logic        exu_redirect,
    input  logic [63:0] exu_next_pc,

    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_ack,

    output logic        rf_wen,
    output logic [63:0] pc,
    output logic [63:0] retired,
    output logic        halt,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_FENCE  = 7'b0001111;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] npc_q, npc_d;
    logic [63:0] retired_q, retired_d;
    logic [31:0] inst_q, inst_d;
    logic [7:0]  timer_q, timer_d;
    logic        err_q, err_d;

    logic        ifu_req_c;
    logic        lsu_req_c;
    logic        lsu_we_c;
    logic        rf_wen_c;

    // Instruction class decode on the latched instruction
    logic [6:0]  opcode;
    logic [4:0]  rd_idx;
    logic        is_load;
    logic        is_store;
    logic        is_ebreak;
    logic        no_rd;
    logic        writes_rd;
    logic        is_mem;

    assign opcode    = inst_q[6:0];
    assign rd_idx    = inst_q[11:7];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_ebreak = (inst_q == EBREAK);
    assign no_rd     = (opcode == OP_BRANCH) || is_store || (opcode == OP_FENCE);
    assign writes_rd = !no_rd && (rd_idx != 5'd0);
    assign is_mem    = is_load || is_store;

    // The timer counts waiting cycles; the limit trips on the cycle that would make it equal MEM_TIMEOUT,
    // and an ack in that same cycle takes priority over the timeout.
    logic [7:0] timer_inc;
    logic       timeout_hit;

    assign timer_inc   = timer_q + 8'd1;
    assign timeout_hit = (timer_inc == MEM_TIMEOUT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        npc_d     = npc_q;
        retired_d = retired_q;
        inst_d    = inst_q;
        timer_d   = timer_q;
        err_d     = err_q;
        ifu_req_c = 1'b0;
        lsu_req_c = 1'b0;
        lsu_we_c  = 1'b0;
        rf_wen_c  = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                ifu_req_c = 1'b1;
                if (ifu_ack) begin
                    inst_d  = ifu_rdata;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_DECODE: begin
                state_d = is_ebreak ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                npc_d = exu_redirect ? exu_next_pc : (pc_q + 64'd4);
                if (is_mem) begin
                    state_d = S_MEM;
                    timer_d = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                lsu_req_c = 1'b1;
                lsu_we_c  = is_store;
                if (lsu_ack) begin
                    state_d = S_WB;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_WB: begin
                rf_wen_c  = writes_rd;
                pc_d      = npc_q;
                retired_d = retired_q + 64'd1;
                timer_d   = 8'd0;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            npc_q     <= RESET_PC;
            retired_q <= 64'd0;
            inst_q    <= 32'd0;
            timer_q   <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            retired_q <= retired_d;
            inst_q    <= inst_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
        end
    end

    // Reset sits in FETCH, so the fetch request is masked while rst is held
    assign ifu_req  = ifu_req_c && !rst;
    assign lsu_req  = lsu_req_c && !rst;
    assign lsu_we   = lsu_we_c && !rst;
    assign rf_wen   = rf_wen_c && !rst;
    assign ifu_addr = pc_q;
    assign pc       = pc_q;
    assign inst     = inst_q;
    assign retired  = retired_q;
    assign halt     = (state_q == S_HALT);
    assign err      = err_q;

endmodule

// File: tb/tb_ysyx_22050612_seq_ctrl.sv
// Directed bench for the sequencer: a vector table of single instructions plus hand sequences
// for reset in MEM, halt behaviour and the fetch/data timeout limit.
module tb_ysyx_22050612_seq_ctrl;

    localparam logic [63:0] RPC    = 64'h0000_0000_8000_0000;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] LOAD   = 32'h0000_B103;
    localparam logic [31:0] STORE  = 32'h0020_B023;
    localparam logic [31:0] BEQ    = 32'h0000_0063;
    localparam logic [31:0] JAL    = 32'h0080_00EF;
    localparam logic [31:0] EBRK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic        ifu_ack = 1'b0;
    logic [31:0] ifu_rdata = 32'd0;
    logic [31:0] inst;
    logic        exu_redirect = 1'b0;
    logic [63:0] exu_next_pc = 64'd0;
    logic        lsu_req;
    logic        lsu_we;
    logic        lsu_ack = 1'b0;
    logic        rf_wen;
    logic [63:0] pc;
    logic [63:0] retired;
    logic        halt;
    logic        err;

    always #5 clk = ~clk;

    ysyx_22050612_seq_ctrl #(
        .RESET_PC    (RPC),
        .MEM_TIMEOUT (8'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_req      (ifu_req),
        .ifu_addr     (ifu_addr),
        .ifu_ack      (ifu_ack),
        .ifu_rdata    (ifu_rdata),
        .inst         (inst),
        .exu_redirect (exu_redirect),
        .exu_next_pc  (exu_next_pc),
        .lsu_req      (lsu_req),
        .lsu_we       (lsu_we),
        .lsu_ack      (lsu_ack),
        .rf_wen       (rf_wen),
        .pc           (pc),
        .retired      (retired),
        .halt         (halt),
        .err          (err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        int          ifu_wait;
        logic        redir;
        logic [63:0] tgt;
        int          lsu_wait;
        logic [63:0] exp_addr;
        int          exp_cycles;
        int          exp_rfw;
        int          exp_lsu;
        logic        exp_we;
        logic [63:0] exp_pc;
        logic [63:0] exp_ret;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[11];

    // Called at a negedge while the DUT is in FETCH; returns at the negedge of the next FETCH (or HALT).
    task automatic run_instr(input vec_t v, output logic [63:0] addr, output int cycles,
                             output int rfw, output int lsu_cnt, output logic we, output logic done);
        int   fw;
        int   lw;
        logic fetched;
        fw = 0; lw = 0; fetched = 1'b0;
        cycles = 0; rfw = 0; lsu_cnt = 0; we = 1'b0; done = 1'b0; addr = 64'd0;
        exu_redirect = v.redir;
        exu_next_pc  = v.tgt;
        while (!done && cycles < 60) begin
            if (fetched && (ifu_req || halt)) begin
                done = 1'b1;
            end else begin
                cycles++;
                if (ifu_req) begin
                    addr = ifu_addr;
                    if (fw == v.ifu_wait) begin
                        ifu_ack   = 1'b1;
                        ifu_rdata = v.rdata;
                        fetched   = 1'b1;
                    end else begin
                        ifu_ack   = 1'b0;
                        ifu_rdata = 32'hDEAD_BEEF;
                        fw++;
                    end
                end else begin
                    ifu_ack = 1'b0;
                end
                if (lsu_req) begin
                    lsu_cnt++;
                    we = lsu_we;
                    if (lw == v.lsu_wait) begin
                        lsu_ack = 1'b1;
                    end else begin
                        lsu_ack = 1'b0;
                        lw++;
                    end
                end else begin
                    lsu_ack = 1'b0;
                end
                if (rf_wen) rfw++;
                @(negedge clk);
            end
        end
        ifu_ack = 1'b0;
        lsu_ack = 1'b0;
    endtask

    logic [63:0] r_addr;
    int          r_cycles, r_rfw, r_lsu;
    logic        r_we, r_done;
    int          busy;

    initial begin
        //             rdata  fw redir tgt                   lw addr                  cyc rfw lsu we  pc                    ret    halt
        vecs[0]  = '{ADDI,  0, 1'b0, 64'd0,                0, 64'h8000_0000,        4,  1,  0, 1'b0, 64'h8000_0004, 64'd1,  1'b0};
        vecs[1]  = '{ADDI,  0, 1'b0, 64'd0,                0, 64'h8000_0004,        4,  1,  0, 1'b0, 64'h8000_0008, 64'd2,  1'b0};
        vecs[2]  = '{ADDI,  0, 1'b0, 64'd0,                0, 64'h8000_0008,        4,  1,  0, 1'b0, 64'h8000_000C, 64'd3,  1'b0};
        vecs[3]  = '{LOAD,  0, 1'b0, 64'd0,                3, 64'h8000_000C,        8,  1,  4, 1'b0, 64'h8000_0010, 64'd4,  1'b0};
        vecs[4]  = '{STORE, 0, 1'b0, 64'd0,                0, 64'h8000_0010,        5,  0,  1, 1'b1, 64'h8000_0014, 64'd5,  1'b0};
        vecs[5]  = '{BEQ,   0, 1'b1, 64'h8000_0100,        0, 64'h8000_0014,        4,  0,  0, 1'b0, 64'h8000_0100, 64'd6,  1'b0};
        vecs[6]  = '{BEQ,   0, 1'b0, 64'h9999_0000,        0, 64'h8000_0100,        4,  0,  0, 1'b0, 64'h8000_0104, 64'd7,  1'b0};
        vecs[7]  = '{ADDI,  2, 1'b0, 64'd0,                0, 64'h8000_0104,        6,  1,  0, 1'b0, 64'h8000_0108, 64'd8,  1'b0};
        vecs[8]  = '{NOP,   0, 1'b0, 64'd0,                0, 64'h8000_0108,        4,  0,  0, 1'b0, 64'h8000_010C, 64'd9,  1'b0};
        vecs[9]  = '{JAL,   0, 1'b1, 64'h8000_0200,        0, 64'h8000_010C,        4,  1,  0, 1'b0, 64'h8000_0200, 64'd10, 1'b0};
        vecs[10] = '{EBRK,  0, 1'b0, 64'd0,                0, 64'h8000_0200,        2,  0,  0, 1'b0, 64'h8000_0200, 64'd10, 1'b1};

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_ifu_req", {63'd0, ifu_req}, 64'd0);
        chk("rst_lsu_req", {63'd0, lsu_req}, 64'd0);
        chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
        chk("rst_pc", pc, RPC);
        chk("rst_retired", retired, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ifu_req", {63'd0, ifu_req}, 64'd1);
        chk("rel_ifu_addr", ifu_addr, RPC);

        for (int i = 0; i < 11; i++) begin
            run_instr(vecs[i], r_addr, r_cycles, r_rfw, r_lsu, r_we, r_done);
            $display("[TB] vec %0d inst=%08h addr=%0h cycles=%0d rf_wen=%0d lsu=%0d we=%0d pc=%0h retired=%0d halt=%0d",
                     i, vecs[i].rdata, r_addr, r_cycles, r_rfw, r_lsu, r_we, pc, retired, halt);
            chk($sformatf("v%0d_done", i), {63'd0, r_done}, 64'd1);
            chk($sformatf("v%0d_addr", i), r_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_cycles", i), 64'(r_cycles), 64'(vecs[i].exp_cycles));
            chk($sformatf("v%0d_rf_wen", i), 64'(r_rfw), 64'(vecs[i].exp_rfw));
            chk($sformatf("v%0d_lsu_cycles", i), 64'(r_lsu), 64'(vecs[i].exp_lsu));
            if (vecs[i].exp_lsu > 0) chk($sformatf("v%0d_lsu_we", i), {63'd0, r_we}, {63'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_retired", i), retired, vecs[i].exp_ret);
            chk($sformatf("v%0d_halt", i), {63'd0, halt}, {63'd0, vecs[i].exp_halt});
            chk($sformatf("v%0d_err", i), {63'd0, err}, 64'd0);
        end

        // Halted core ignores acks and issues nothing
        busy = 0;
        for (int c = 0; c < 6; c++) begin
            ifu_ack = 1'b1;
            lsu_ack = 1'b1;
            @(negedge clk);
            if (ifu_req || lsu_req || rf_wen) busy++;
        end
        ifu_ack = 1'b0;
        lsu_ack = 1'b0;
        $display("[TB] halt hold: busy=%0d pc=%0h retired=%0d inst=%08h", busy, pc, retired, inst);
        chk("halt_no_req", 64'(busy), 64'd0);
        chk("halt_sticky", {63'd0, halt}, 64'd1);
        chk("halt_pc", pc, 64'h8000_0200);
        chk("halt_retired", retired, 64'd10);
        chk("halt_inst", {32'd0, inst}, {32'd0, EBRK});

        // Reset while a load is waiting in MEM
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_instr(vecs[0], r_addr, r_cycles, r_rfw, r_lsu, r_we, r_done);
        ifu_ack = 1'b1;
        ifu_rdata = LOAD;
        @(negedge clk);
        ifu_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_mem_lsu_req", {63'd0, lsu_req}, 64'd1);
        chk("mid_mem_lsu_we", {63'd0, lsu_we}, 64'd0);
        chk("mid_mem_retired", retired, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] reset in MEM: lsu_req=%0d pc=%0h retired=%0d", lsu_req, pc, retired);
        chk("mid_rst_lsu_req", {63'd0, lsu_req}, 64'd0);
        chk("mid_rst_pc", pc, RPC);
        chk("mid_rst_retired", retired, 64'd0);
        chk("mid_rst_ifu_req", {63'd0, ifu_req}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ifu_req", {63'd0, ifu_req}, 64'd1);
        chk("mid_rel_ifu_addr", ifu_addr, RPC);

        // Fetch timeout: four waiting cycles with MEM_TIMEOUT=4
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("fto_before_halt", {63'd0, halt}, 64'd0);
        chk("fto_before_req", {63'd0, ifu_req}, 64'd1);
        @(negedge clk);
        $display("[TB] fetch timeout: halt=%0d err=%0d ifu_req=%0d", halt, err, ifu_req);
        chk("fto_halt", {63'd0, halt}, 64'd1);
        chk("fto_err", {63'd0, err}, 64'd1);
        chk("fto_ifu_req", {63'd0, ifu_req}, 64'd0);

        // Ack on the limit cycle wins, then the load times out in MEM
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_clears_err", {63'd0, err}, 64'd0);
        for (int c = 0; c < 3; c++) @(negedge clk);
        ifu_ack = 1'b1;
        ifu_rdata = LOAD;
        @(negedge clk);
        ifu_ack = 1'b0;
        $display("[TB] ack at limit: halt=%0d err=%0d ifu_req=%0d inst=%08h", halt, err, ifu_req, inst);
        chk("lim_ack_halt", {63'd0, halt}, 64'd0);
        chk("lim_ack_err", {63'd0, err}, 64'd0);
        chk("lim_ack_ifu_req", {63'd0, ifu_req}, 64'd0);
        chk("lim_ack_inst", {32'd0, inst}, {32'd0, LOAD});
        @(negedge clk);
        @(negedge clk);
        chk("mto_lsu_req", {63'd0, lsu_req}, 64'd1);
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("mto_before_halt", {63'd0, halt}, 64'd0);
        @(negedge clk);
        $display("[TB] mem timeout: halt=%0d err=%0d lsu_req=%0d retired=%0d", halt, err, lsu_req, retired);
        chk("mto_halt", {63'd0, halt}, 64'd1);
        chk("mto_err", {63'd0, err}, 64'd1);
        chk("mto_lsu_req_off", {63'd0, lsu_req}, 64'd0);
        chk("mto_retired", retired, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
